rca_share_sched: RTL and testbench

Round-robin scheduler that shares one W-bit ripple-carry adder between NREQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester at a time, registers its operands and carry-in, and returns the sum and carry-out tagged with the requester id on a single backpressured response channel. It sits between client datapaths and the shared adder slice, so the team needs only one adder instance per cluster.

---
 rtl/rca_sched_pkg.sv | 14 +
 rtl/rca_rr_arb.sv | 32 +++
 rtl/rca_share_sched.sv | 109 ++++++++++
 tb/tb_rca_share_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rca_sched_pkg.sv
// Shared types and constants for the shared ripple-carry adder scheduler.
package rca_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int OPCNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rca_rr_arb.sv
// Combinational round-robin arbiter: first requester with a request,
// searching upward from last+1 and wrapping modulo NREQ.
module rca_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] idx;

    // Walk the ring once starting just past the previous winner.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/rca_share_sched.sv
// Shares one W-bit adder between NREQ requesters: grant one, add, return
// the tagged result on a backpressured response channel.
module rca_share_sched
    import rca_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy,
    output logic [OPCNT_W-1:0]   op_count
);

    state_t         state, state_nx;
    logic [IDW-1:0] last;
    logic [W-1:0]   a_r, b_r;
    logic           cin_r;
    logic [IDW-1:0] id_r;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    logic           any;
    logic           accept;
    logic [W:0]     add_full;

    rca_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .last   (last),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // Carry-out is kept as the extra top bit of the sum.
    assign add_full = {1'b0, a_r} + {1'b0, b_r} + {{W{1'b0}}, cin_r};

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Next-state and grant decode; only IDLE can accept a new operation.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: if (any) begin
                req_ready = gnt;
                accept    = 1'b1;
                state_nx  = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, round-robin pointer and completion counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= IDW'(NREQ - 1);
            op_count <= '0;
        end else begin
            state <= state_nx;
            if (accept) last <= gnt_id;
            if (state == RESP && rsp_ready) op_count <= op_count + 1'b1;
        end
    end

    // Operands are sampled only in the accepting cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            cin_r <= 1'b0;
            id_r  <= '0;
        end else if (accept) begin
            a_r   <= req_a[gnt_id*W +: W];
            b_r   <= req_b[gnt_id*W +: W];
            cin_r <= req_cin[gnt_id];
            id_r  <= gnt_id;
        end
    end

    // Response registers load at the end of EXEC and hold through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id   <= id_r;
            rsp_sum  <= add_full[W-1:0];
            rsp_cout <= add_full[W];
        end
    end

endmodule

// File: tb/tb_rca_share_sched.sv
// Randomized and directed bench for rca_share_sched against a
// transaction-level reference model.
module tb_rca_share_sched;
    import rca_sched_pkg::*;

    localparam int NREQ = NREQ_DEF;
    localparam int W    = W_DEF;
    localparam int IDW  = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic [NREQ-1:0]     req_cin;
    logic                rsp_valid, rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_sum;
    logic                rsp_cout, busy;
    logic [OPCNT_W-1:0]  op_count;

    rca_share_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one outstanding transaction and what the response
    // port currently shows.
    int m_last;
    bit pend;
    int phase;            // 1: adding, 2: response presented
    int p_id, p_sum, p_cout;
    int sh_id, sh_sum, sh_cout;
    int m_cnt;
    int grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend = 0; phase = 0; m_last = NREQ - 1;
        sh_id = 0; sh_sum = 0; sh_cout = 0; m_cnt = 0;
    endtask

    // One clock: check at negedge against the model, advance the model to
    // what the next edge does, and return just after that edge.
    task automatic step();
        int win;
        int s;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        win = -1;
        exp_rdy = '0;
        if (!pend)
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (win < 0 && req_valid[i]) win = i;
            end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(pend && phase == 2));
        chk("busy",      32'(busy),      32'(pend));
        chk("rsp_id",    32'(rsp_id),    sh_id);
        chk("rsp_sum",   32'(rsp_sum),   sh_sum);
        chk("rsp_cout",  32'(rsp_cout),  sh_cout);
        chk("op_count",  32'(op_count),  m_cnt);
        if (reset) begin
            model_reset();
        end else if (!pend && win >= 0) begin
            s = int'(req_a[win*W +: W]) + int'(req_b[win*W +: W]) + int'(req_cin[win]);
            pend = 1; phase = 1; m_last = win; p_id = win;
            p_sum = s % (1 << W); p_cout = s >> W;
            grants.push_back(win);
        end else if (pend && phase == 1) begin
            phase = 2; sh_id = p_id; sh_sum = p_sum; sh_cout = p_cout;
        end else if (pend && phase == 2 && rsp_ready) begin
            pend = 0; m_cnt = (m_cnt + 1) % 65536;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input int a, input int b, input bit c);
        req_a[r*W +: W] = W'(a);
        req_b[r*W +: W] = W'(b);
        req_cin[r] = c;
    endtask

    task automatic rand_ops();
        req_a = '0; req_b = '0;
        for (int r = 0; r < NREQ; r++) set_op(r, $urandom, $urandom, 1'($urandom));
    endtask

    task automatic drain();
        req_valid = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        rsp_ready = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        step();                         // reset state seen by the model

        // Single request: 0xFF + 0x01 -> 0x00 carry 1, tagged id 2.
        set_op(2, 8'hFF, 8'h01, 1'b0);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step(); step();
        chk("single_sum",  32'(rsp_sum),  32'h00);
        chk("single_cout", 32'(rsp_cout), 32'h1);
        chk("single_id",   32'(rsp_id),   32'h2);
        drain();
        chk("single_cnt",  32'(op_count), 32'h1);

        // Round robin from reset: grants 0,1,2,3,0.
        do_reset();
        grants.delete();
        req_valid = '1;
        for (int i = 0; i < 15; i++) begin rand_ops(); step(); end
        for (int i = 0; i < 5; i++)
            chk("rr_order", (grants.size() > i) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(i % NREQ));
        drain();

        // Backpressure: hold the response for 5 cycles, then release.
        req_valid = '1; rsp_ready = 1'b0;
        for (int i = 0; i < 10 && !(pend && phase == 2); i++) begin rand_ops(); step(); end
        chk("bp_pending", 32'(pend && phase == 2), 32'h1);
        for (int i = 0; i < 5; i++) begin rand_ops(); step(); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin rand_ops(); step(); end
        drain();

        // Carry-in corner cases on requester 1.
        set_op(1, 8'h7F, 8'h80, 1'b1); req_valid = 4'b0010;
        step(); req_valid = '0; step(); step();
        chk("cin_sum0",  32'(rsp_sum),  32'h00);
        chk("cin_cout0", 32'(rsp_cout), 32'h1);
        drain();
        set_op(1, 0, 0, 1'b1); req_valid = 4'b0010;
        step(); req_valid = '0; step(); step();
        chk("cin_sum1",  32'(rsp_sum),  32'h01);
        chk("cin_cout1", 32'(rsp_cout), 32'h0);
        drain();

        // Operand change after accept must not affect the result.
        set_op(0, 8'h10, 8'h20, 1'b0); req_valid = 4'b0001;
        step();
        req_valid = '0; set_op(0, 8'hAA, 8'h20, 1'b0);
        step(); step();
        chk("late_change", 32'(rsp_sum), 32'h30);
        drain();

        // Reset while in EXEC drops the operation; requester 0 wins next.
        req_valid = '1; rand_ops();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_grant", 32'(req_ready), 32'h1);
        step();
        drain();

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            req_valid = NREQ'($urandom);
            rand_ops();
            rsp_ready = ($urandom_range(3) != 0);
            reset = ($urandom_range(99) == 0);
            step();
        end
        reset = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
